chain_counter: RTL and testbench
================================

Name: chain_counter

Overview:
Parameterised successor to the single-stage modulo counter. It cascades NumStages counter stages of DataWidth bits each, for example pixel, cell and row counters in the VGA timing and cell-grid logic. Each stage has a run-time terminal value, and the chain supports up/down counting, synchronous load, per-stage terminal flags and a chain carry-out.

Parameters:
NumStages, 2, number of cascaded stages (>=1); stage 0 is least significant
DataWidth, 4, bits per stage (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  synchronous, active-low reset
en  input  1  count enable for stage 0
up  input  1  direction: 1 = count up, 0 = count down
load  input  1  synchronous load strobe
load_val  input  NumStages*DataWidth  load value; stage i is bits [i*DataWidth +: DataWidth]
max_cnt  input  NumStages*DataWidth  per-stage terminal value, same packing
Q  output  NumStages*DataWidth  counter value, same packing
tc  output  NumStages  per-stage terminal-count strobe (combinational)
carry_out  output  1  chain carry/borrow-out (combinational)

Behaviour:
- Reset: reset_n low at a clk edge forces Q <= 0 in every stage. Reset overrides load and en. tc and carry_out are then 0 unless en is high with the reset state terminal.
- Stage increment strobe: inc[0] = en & ~load; inc[i] = inc[i-1] & term[i-1].
- Terminal condition, up=1: term[i] = (Q_i >= max_cnt_i). The >= lets a stage sitting above a newly lowered max wrap on its next step.
- Terminal condition, up=0: term[i] = (Q_i == 0).
- tc[i] = inc[i] & term[i]. carry_out = tc[NumStages-1], which is high only when all stages are terminal and the chain is enabled.
- Step, up=1: when inc[i] is high, Q_i <= term[i] ? 0 : Q_i + 1.
- Step, up=0: when inc[i] is high, Q_i <= term[i] ? max_cnt_i : Q_i - 1.
- Latency: Q updates one clk after the strobe. tc and carry_out are same-cycle, like the legacy TC.
- Load: load=1 with reset_n=1 sets each stage Q_i <= min(load_val_i, max_cnt_i). Load has priority over en. tc and carry_out are 0 during a load cycle.
- max_cnt_i = 0: stage i holds at 0 and is always terminal, so it passes every strobe straight through.
- Direction change: takes effect on the same edge it is sampled; there is no pipeline.
- Arithmetic: unsigned, modulo 2^DataWidth. A stage never escapes [0, 2^DataWidth-1].
- Stalls: with en=0 and load=0 the chain holds all Q values.

Optional Feature:
Macro CHAIN_COUNTER_SAT_EN.
- Defined: adds input port sat (1 bit). When sat=1 and every term[i] is high with en=1, Q holds instead of wrapping and carry_out stays high every enabled cycle. Load and reset behave as normal.
- Undefined: port sat is absent and the chain always wraps.

Decomposition:
- Shared package/header chain_counter_pkg:
  - direction encodings DIR_UP=1'b1, DIR_DOWN=1'b0
  - a stage-slice helper (index to bit offset) used for load_val/max_cnt/Q packing
- One natural sub-module, counter_stage: one DataWidth-bit stage with inputs inc, up, load, load_val, max_cnt, hold (saturation) and outputs Q, term. chain_counter instantiates NumStages of them with a generate loop and derives the inc chain, tc and carry_out.

Test Plan:
All scenarios use NumStages=2 and DataWidth=4.
1. Reset: reset_n=0 with en=1, load=1, load_val=0x37 -> next edge Q=0x00; after release with en=0, Q holds 0x00.
2. Up count: max_cnt={9,5}, up=1, en=1 for 60 cycles from 0 -> stage0 sequence 0..5 wrapping; tc[0] high at Q0=5; stage1 increments on each tc[0]. carry_out pulses exactly once, at Q={9,5}, and the next Q is {0,0}; the pattern repeats every 60 cycles.
3. Down count: up=0, en=1 from Q={0,0} with max_cnt={9,5} -> tc={1,1}, carry_out=1 that cycle, next Q={9,5}; then Q={9,4}, with no carry.
4. Load clamp and priority:
   - load=1, en=1, load_val={3,7}, max_cnt={9,5} -> next Q={3,5}; tc=0 and carry_out=0 in the load cycle.
   - load_val={12,2} -> next Q={9,2}.
5. Run-time max reduction: Q0=4, change max_cnt0 to 2, en=1 -> tc[0]=1 that cycle, next Q0=0, and stage1 increments by 1.
6. Saturation (CHAIN_COUNTER_SAT_EN defined):
   - sat=1 at Q={9,5} with en=1 for 3 cycles -> Q stays {9,5} and carry_out=1 each cycle.
   - Set sat=0 -> next Q={0,0}.

Source files
------------

// File: rtl/chain_counter_pkg.sv
// Shared definitions for the cascaded chain counter: direction encodings and
// the helper that maps a stage index to its bit offset in packed buses.
package chain_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Bit offset of stage idx within a bus packing stages of the given width
  function automatic int unsigned stage_lsb(input int unsigned idx,
                                            input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/chain_counter_stage.sv
// One stage of the chain counter: wraps at a run-time terminal value in either
// direction, with clamped synchronous load and a hold input for saturation.
module counter_stage
  import chain_counter_pkg::*;
#(
  parameter int unsigned DataWidth = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 inc,
  input  logic                 up,
  input  logic                 load,
  input  logic [DataWidth-1:0] load_val,
  input  logic [DataWidth-1:0] max_cnt,
  input  logic                 hold,
  output logic [DataWidth-1:0] Q,
  output logic                 term
);

  logic [DataWidth-1:0] q_next;
  logic [DataWidth-1:0] load_clamped;

  // Going up, >= lets a stage above a freshly lowered terminal wrap next step
  always_comb begin
    term = 1'b0;
    if (up == DIR_UP) begin
      term = (Q >= max_cnt);
    end else begin
      term = (Q == '0);
    end
  end

  always_comb begin
    load_clamped = (load_val > max_cnt) ? max_cnt : load_val;
    q_next       = Q;
    if (load) begin
      q_next = load_clamped;
    end else if (inc && !hold) begin
      if (up == DIR_UP) begin
        q_next = term ? '0 : DataWidth'(Q + DataWidth'(1));
      end else begin
        q_next = term ? max_cnt : DataWidth'(Q - DataWidth'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      Q <= '0;
    end else begin
      Q <= q_next;
    end
  end

endmodule

// File: rtl/chain_counter.sv
// Cascade of NumStages counter stages with a ripple increment chain, per-stage
// terminal strobes and chain carry-out. Define CHAIN_COUNTER_SAT_EN for the sat input.
module chain_counter
  import chain_counter_pkg::*;
#(
  parameter int unsigned NumStages = 2,
  parameter int unsigned DataWidth = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           en,
  input  logic                           up,
  input  logic                           load,
`ifdef CHAIN_COUNTER_SAT_EN
  input  logic                           sat,
`endif
  input  logic [NumStages*DataWidth-1:0] load_val,
  input  logic [NumStages*DataWidth-1:0] max_cnt,
  output logic [NumStages*DataWidth-1:0] Q,
  output logic [NumStages-1:0]           tc,
  output logic                           carry_out
);

  logic [NumStages-1:0] inc;
  logic [NumStages-1:0] term;
  logic                 hold;

  // Saturation freezes the whole chain once every stage is terminal
`ifdef CHAIN_COUNTER_SAT_EN
  assign hold = sat & en & ~load & (&term);
`else
  assign hold = 1'b0;
`endif

  assign inc[0] = en & ~load;

  for (genvar i = 1; i < NumStages; i++) begin : g_inc
    assign inc[i] = inc[i-1] & term[i-1];
  end

  for (genvar i = 0; i < NumStages; i++) begin : g_stage
    counter_stage #(
      .DataWidth (DataWidth)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .inc      (inc[i]),
      .up       (up),
      .load     (load),
      .load_val (load_val[stage_lsb(i, DataWidth) +: DataWidth]),
      .max_cnt  (max_cnt[stage_lsb(i, DataWidth) +: DataWidth]),
      .hold     (hold),
      .Q        (Q[stage_lsb(i, DataWidth) +: DataWidth]),
      .term     (term[i])
    );
  end

  assign tc        = inc & term;
  assign carry_out = tc[NumStages-1];

endmodule

// File: tb/tb_chain_counter.sv
// Directed self-checking bench for chain_counter with two 4-bit stages.
// Saturation checks are included when CHAIN_COUNTER_SAT_EN is defined.
module tb_chain_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] max_cnt;
  logic [7:0] Q;
  logic [1:0] tc;
  logic       carry_out;
`ifdef CHAIN_COUNTER_SAT_EN
  logic       sat;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chain_counter #(
    .NumStages (2),
    .DataWidth (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .up        (up),
    .load      (load),
`ifdef CHAIN_COUNTER_SAT_EN
    .sat       (sat),
`endif
    .load_val  (load_val),
    .max_cnt   (max_cnt),
    .Q         (Q),
    .tc        (tc),
    .carry_out (carry_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int carries;
  int q0;
  int q1;

  initial begin
    reset_n  = 1'b0;
    en       = 1'b1;
    up       = 1'b1;
    load     = 1'b1;
    load_val = 8'h37;
    max_cnt  = 8'h95;
`ifdef CHAIN_COUNTER_SAT_EN
    sat      = 1'b0;
`endif

    // Reset overrides load and en
    tick();
    check("reset_q", 32'(Q), 32'h00);
    reset_n = 1'b1;
    load    = 1'b0;
    en      = 1'b0;
    @(negedge clk);
    check("idle_tc", 32'(tc), 32'h0);
    tick();
    check("hold_after_reset", 32'(Q), 32'h00);

    // Up count through a full 60-cycle period
    en      = 1'b1;
    carries = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      check("up_tc0", 32'(tc[0]), 32'((k % 6) == 5));
      check("up_carry", 32'(carry_out), 32'(k == 59));
      if (carry_out) carries++;
      tick();
      q0 = (k + 1) % 6;
      q1 = ((k + 1) / 6) % 10;
      check("up_q", 32'(Q), 32'((q1 << 4) | q0));
    end
    check("up_carry_count", 32'(carries), 32'd1);

    // Down count from zero wraps to the terminal values
    up = 1'b0;
    @(negedge clk);
    check("down_tc", 32'(tc), 32'h3);
    check("down_carry", 32'(carry_out), 32'h1);
    tick();
    check("down_wrap_q", 32'(Q), 32'h95);
    @(negedge clk);
    check("down_carry2", 32'(carry_out), 32'h0);
    tick();
    check("down_step_q", 32'(Q), 32'h94);

    // Load wins over en and clamps to max_cnt
    up       = 1'b1;
    load     = 1'b1;
    load_val = 8'h37;
    @(negedge clk);
    check("load_tc", 32'(tc), 32'h0);
    check("load_carry", 32'(carry_out), 32'h0);
    tick();
    check("load_clamp_q", 32'(Q), 32'h35);
    load_val = 8'hC2;
    tick();
    check("load_clamp_hi_q", 32'(Q), 32'h92);

    // Lowering max below the current value wraps on the next step
    load_val = 8'h34;
    tick();
    check("load_34", 32'(Q), 32'h34);
    load    = 1'b0;
    max_cnt = 8'h92;
    @(negedge clk);
    check("maxdrop_tc", 32'(tc), 32'h1);
    tick();
    check("maxdrop_q", 32'(Q), 32'h40);

    // Zero terminal makes stage 0 pass every strobe through
    max_cnt  = 8'h90;
    load     = 1'b1;
    load_val = 8'h47;
    tick();
    check("load_max0", 32'(Q), 32'h40);
    load = 1'b0;
    @(negedge clk);
    check("max0_tc", 32'(tc), 32'h1);
    tick();
    check("max0_q", 32'(Q), 32'h50);

    // Stall holds
    en = 1'b0;
    max_cnt = 8'h95;
    tick();
    tick();
    check("stall_q", 32'(Q), 32'h50);

`ifdef CHAIN_COUNTER_SAT_EN
    load     = 1'b1;
    load_val = 8'h95;
    tick();
    load = 1'b0;
    en   = 1'b1;
    sat  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("sat_carry", 32'(carry_out), 32'h1);
      tick();
      check("sat_q", 32'(Q), 32'h95);
    end
    sat = 1'b0;
    tick();
    check("unsat_q", 32'(Q), 32'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
